app_csr_mmio_responder: RTL and testbench
=========================================

Name: app_csr_mmio_responder

Overview:
- Host-facing responder for the application CSR interface. Decodes MMIO read and write requests, drives one-cycle write strobes to application CSRs, and returns 64-bit read responses.
- Read responses carry the DFH, the AFU ID, local manager CSRs and the application read CSRs.
- Sits between the host MMIO channel and the application module, acting as the CSR manager end of the app/csr port pair.

Parameters:
- NUM_APP_CSRS, 1, number of application read/write CSR slots.
- RESET_CYCLES, 16, soft-reset pulse length in clk cycles (>=1).
- DFH_VALUE, 64'h1000_0100_0000_0000, constant returned at register index 0 (type=AFU, end-of-list).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- mmio_wr_valid  in  1  host write request, single-cycle.
- mmio_rd_valid  in  1  host read request, single-cycle.
- mmio_addr  in  16  32-bit-word address, shared by read and write.
- mmio_wr_data  in  64  write payload.
- mmio_rd_tid  in  9  read transaction ID.
- mmio_rsp_valid  out  1  read response strobe.
- mmio_rsp_tid  out  9  echoed TID.
- mmio_rsp_data  out  64  read data.
- app_afu_id  in  128  AFU ID from the application.
- app_rd_data  in  32*NUM_APP_CSRS  application read CSRs; slot i occupies bits [32i+31:32i].
- app_wr_en  out  NUM_APP_CSRS  per-slot write strobe.
- app_wr_data  out  32  write data, shared by all slots.
- app_reset_n  out  1  soft reset to the application, active-low.

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low; all state clears immediately on assertion.
- Reset values: mmio_rsp_valid=0, mmio_rsp_tid=0, mmio_rsp_data=0, app_wr_en=0, app_wr_data=0, app_reset_n=0. app_reset_n rises on the first clk edge after reset_n deasserts.
- Addressing: all accesses are 64-bit. Register index = mmio_addr[15:1]. mmio_addr[0]=1: read returns 0, write ignored.
- Register map (index: content):
  - 0: DFH_VALUE.
  - 1: app_afu_id[63:0].
  - 2: app_afu_id[127:64].
  - 3-4: 0.
  - 8: RESET_CSR. Read = {63'b0, soft reset active}. A write with bit0=1 triggers soft reset.
  - 9: cycle counter (see optional feature).
  - 10: write counter, 40-bit, zero-extended.
  - 11-13: 0.
  - 16+i (i<NUM_APP_CSRS): read = {32'b0, app_rd_data slot i}; write drives app slot i.
  - All other indices: read 0, write ignored.
- Read pipeline:
  - Stage 1 registers index and TID at T+1. Data is muxed from stage-1 values.
  - mmio_rsp_valid pulses exactly one cycle at T+2, carrying the TID from T.
  - Back-to-back reads every cycle are accepted. No backpressure; responses stay in order.
- Write path: a write at T to index 16+i pulses app_wr_en[i] for exactly one cycle at T+1, with app_wr_data = mmio_wr_data[31:0].
- Write counter: increments by 1 for each accepted app-slot write. Wraps at 2^40. Cleared when soft reset triggers.
- Soft reset:
  - Triggered by a RESET_CSR write with bit0=1 at T.
  - app_reset_n is low from T+1 for exactly RESET_CYCLES cycles.
  - A retrigger while active restarts the full count.
  - While app_reset_n is low, app-slot writes are dropped: no strobe, no count. Reads still answer normally.
- Simultaneous read and write in the same cycle: both are accepted. The read returns pre-write state; e.g. the write counter read at T excludes the write at T.
- reset_n asserted mid-read: in-flight responses are discarded; no response is issued after reset.

Optional Feature:
- Macro: CSR_MGR_CYCLE_COUNTER_EN.
- Defined: 40-bit free-running counter, cleared only by reset_n, wraps at 2^40. Read at index 9, zero-extended; the returned value is the count at read stage 1.
- Undefined: no counter logic is built; index 9 reads 0.

Test Plan:
- Read index 0 with TID 0x05 at T -> rsp_valid at T+2, tid=0x05, data=64'h1000_0100_0000_0000.
- app_afu_id=128'hAAAA..._5555...; read index 1, then index 2 on consecutive cycles -> two consecutive responses with the low half then the high half, TIDs preserved.
- Write 64'hFFFF_FFFF_1234_5678 to index 16 -> app_wr_en[0]=1 for one cycle at T+1, app_wr_data=32'h1234_5678; write counter reads 1.
- RESET_CSR write bit0=1 at T, retrigger at T+5 -> app_reset_n low T+1..T+5+RESET_CYCLES; an app write during this window produces no strobe; write counter reads 0.
- Odd address 16'h0021 read/write -> read returns 0, no app_wr_en.
- With CSR_MGR_CYCLE_COUNTER_EN: two reads of index 9 issued 10 cycles apart -> values differ by exactly 10. Without the macro -> both reads return 0.

Source files
------------

// File: rtl/app_csr_mmio_responder_if.sv
// Host MMIO channel between the host and the CSR responder.
// Requests: wr/rd valid, addr, wr_data, rd_tid; response: rsp valid/tid/data.
interface app_csr_mmio_responder_if;
   logic        mmio_wr_valid;
   logic        mmio_rd_valid;
   logic [15:0] mmio_addr;
   logic [63:0] mmio_wr_data;
   logic [8:0]  mmio_rd_tid;
   logic        mmio_rsp_valid;
   logic [8:0]  mmio_rsp_tid;
   logic [63:0] mmio_rsp_data;

   modport master (
      output mmio_wr_valid, mmio_rd_valid, mmio_addr,
      output mmio_wr_data, mmio_rd_tid,
      input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
   );

   modport slave (
      input  mmio_wr_valid, mmio_rd_valid, mmio_addr,
      input  mmio_wr_data, mmio_rd_tid,
      output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
   );
endinterface

// File: rtl/app_csr_mmio_responder.sv
// CSR manager: decodes host MMIO, strobes app CSR writes, returns reads.
// Ports: clk, reset_n, mmio (slave), app_afu_id, app_rd_data, app_wr_en,
// app_wr_data, app_reset_n. Macro CSR_MGR_CYCLE_COUNTER_EN adds a
// 40-bit free-running cycle counter at index 9.
module app_csr_mmio_responder #(
   parameter int unsigned NUM_APP_CSRS = 1,
   parameter int unsigned RESET_CYCLES = 16,
   parameter logic [63:0] DFH_VALUE    = 64'h1000_0100_0000_0000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   app_csr_mmio_responder_if.slave     mmio,
   input  logic [127:0]                app_afu_id,
   input  logic [32*NUM_APP_CSRS-1:0]  app_rd_data,
   output logic [NUM_APP_CSRS-1:0]     app_wr_en,
   output logic [31:0]                 app_wr_data,
   output logic                        app_reset_n
);

   localparam int CW = $clog2(RESET_CYCLES + 1);

   logic [14:0]             idx;
   logic                    odd;
   logic                    soft_trig;
   logic                    app_wr;
   logic [NUM_APP_CSRS-1:0] wr_en_d;
   logic [63:0]             rd_data_d;
   logic [39:0]             cyc_rd;

   logic                    s1_v_q;
   logic [14:0]             s1_idx_q;
   logic                    s1_odd_q;
   logic [8:0]              s1_tid_q;
   logic [39:0]             s1_wcnt_q;
   logic                    s1_act_q;

   logic                    rsp_valid_q;
   logic [8:0]              rsp_tid_q;
   logic [63:0]             rsp_data_q;
   logic [NUM_APP_CSRS-1:0] wr_en_q;
   logic [31:0]             wr_data_q;
   logic [39:0]             wcnt_q;
   logic [CW-1:0]           rst_cnt_q;
   logic                    arn_q;

   logic unused_wr_hi;
   assign unused_wr_hi = ^mmio.mmio_wr_data[63:32];

   assign idx = mmio.mmio_addr[15:1];
   assign odd = mmio.mmio_addr[0];

   assign soft_trig = mmio.mmio_wr_valid & ~odd
                    & (idx == 15'd8) & mmio.mmio_wr_data[0];

   // App-slot writes are dropped while the application is held in reset.
   always_comb begin
      wr_en_d = '0;
      for (int unsigned i = 0; i < NUM_APP_CSRS; i++) begin
         wr_en_d[i] = mmio.mmio_wr_valid & ~odd & arn_q
                    & (idx == 15'(16 + i));
      end
   end

   assign app_wr = |wr_en_d;

`ifdef CSR_MGR_CYCLE_COUNTER_EN
   logic [39:0] cyc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc_q <= '0;
      else          cyc_q <= cyc_q + 40'd1;
   end

   assign cyc_rd = cyc_q;
`else
   assign cyc_rd = '0;
`endif

   // Write counter and reset status are snapshotted at request time so a
   // same-cycle write is not visible; the rest is sampled at stage 1.
   always_comb begin
      rd_data_d = '0;
      if (!s1_odd_q) begin
         case (s1_idx_q)
            15'd0:   rd_data_d = DFH_VALUE;
            15'd1:   rd_data_d = app_afu_id[63:0];
            15'd2:   rd_data_d = app_afu_id[127:64];
            15'd8:   rd_data_d = {63'b0, s1_act_q};
            15'd9:   rd_data_d = {24'b0, cyc_rd};
            15'd10:  rd_data_d = {24'b0, s1_wcnt_q};
            default: rd_data_d = '0;
         endcase
         for (int unsigned i = 0; i < NUM_APP_CSRS; i++) begin
            if (s1_idx_q == 15'(16 + i)) begin
               rd_data_d = {32'b0, app_rd_data[32*i +: 32]};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_v_q      <= 1'b0;
         s1_idx_q    <= '0;
         s1_odd_q    <= 1'b0;
         s1_tid_q    <= '0;
         s1_wcnt_q   <= '0;
         s1_act_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         wr_en_q     <= '0;
         wr_data_q   <= '0;
         wcnt_q      <= '0;
         rst_cnt_q   <= '0;
         arn_q       <= 1'b0;
      end else begin
         s1_v_q    <= mmio.mmio_rd_valid;
         s1_idx_q  <= idx;
         s1_odd_q  <= odd;
         s1_tid_q  <= mmio.mmio_rd_tid;
         s1_wcnt_q <= wcnt_q;
         s1_act_q  <= ~arn_q;

         rsp_valid_q <= s1_v_q;
         if (s1_v_q) begin
            rsp_tid_q  <= s1_tid_q;
            rsp_data_q <= rd_data_d;
         end

         wr_en_q <= wr_en_d;
         if (app_wr) wr_data_q <= mmio.mmio_wr_data[31:0];

         if (soft_trig)   wcnt_q <= '0;
         else if (app_wr) wcnt_q <= wcnt_q + 40'd1;

         // Count loads on trigger; app_reset_n releases after the
         // last count, giving exactly RESET_CYCLES low cycles.
         if (soft_trig) begin
            rst_cnt_q <= CW'(RESET_CYCLES);
            arn_q     <= 1'b0;
         end else if (rst_cnt_q != '0) begin
            rst_cnt_q <= rst_cnt_q - CW'(1);
            arn_q     <= (rst_cnt_q == CW'(1));
         end else begin
            arn_q     <= 1'b1;
         end
      end
   end

   assign mmio.mmio_rsp_valid = rsp_valid_q;
   assign mmio.mmio_rsp_tid   = rsp_tid_q;
   assign mmio.mmio_rsp_data  = rsp_data_q;
   assign app_wr_en           = wr_en_q;
   assign app_wr_data         = wr_data_q;
   assign app_reset_n         = arn_q;

endmodule

// File: tb/tb_app_csr_mmio_responder.sv
// Directed bench for app_csr_mmio_responder.
// Hand-computed vectors; all comparisons go through chk.
module tb_app_csr_mmio_responder;
   logic         clk = 1'b0;
   logic         reset_n;
   logic [127:0] afu;
   logic [31:0]  app_rd;
   logic [0:0]   wr_en;
   logic [31:0]  wr_data;
   logic         arn;
   int           n_chk = 0;
   int           n_err = 0;
   logic [63:0]  c0, c1;

   localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;

   always #5 clk = ~clk;

   app_csr_mmio_responder_if mmio ();

   app_csr_mmio_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mmio        (mmio),
      .app_afu_id  (afu),
      .app_rd_data (app_rd),
      .app_wr_en   (wr_en),
      .app_wr_data (wr_data),
      .app_reset_n (arn)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      mmio.mmio_wr_valid = 1'b0;
      mmio.mmio_rd_valid = 1'b0;
      mmio.mmio_addr     = '0;
      mmio.mmio_wr_data  = '0;
      mmio.mmio_rd_tid   = '0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a,
                     input logic [8:0] t, input logic [63:0] exp);
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = a;
      mmio.mmio_rd_tid   = t;
      tick;
      idle;
      tick;
      chk({tag, ".v"}, 64'(mmio.mmio_rsp_valid), 64'd1);
      chk({tag, ".tid"}, 64'(mmio.mmio_rsp_tid), 64'(t));
      chk({tag, ".d"}, mmio.mmio_rsp_data, exp);
      tick;
      chk({tag, ".v0"}, 64'(mmio.mmio_rsp_valid), 64'd0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      mmio.mmio_wr_valid = 1'b1;
      mmio.mmio_addr     = a;
      mmio.mmio_wr_data  = d;
      tick;
      idle;
   endtask

   initial begin
      reset_n = 1'b0;
      idle;
      afu    = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
      app_rd = 32'hCAFE_F00D;
      #12;
      chk("rst.v", 64'(mmio.mmio_rsp_valid), 64'd0);
      chk("rst.tid", 64'(mmio.mmio_rsp_tid), 64'd0);
      chk("rst.d", mmio.mmio_rsp_data, 64'd0);
      chk("rst.wen", 64'(wr_en), 64'd0);
      chk("rst.wd", 64'(wr_data), 64'd0);
      chk("rst.arn", 64'(arn), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick;
      chk("rst.arn_up", 64'(arn), 64'd1);

      rd("dfh", 16'h0000, 9'h005, DFH);

      // Back-to-back reads of the AFU ID halves.
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = 16'h0002;
      mmio.mmio_rd_tid   = 9'h011;
      tick;
      mmio.mmio_addr     = 16'h0004;
      mmio.mmio_rd_tid   = 9'h012;
      tick;
      idle;
      chk("afu_lo.v", 64'(mmio.mmio_rsp_valid), 64'd1);
      chk("afu_lo.tid", 64'(mmio.mmio_rsp_tid), 64'h11);
      chk("afu_lo.d", mmio.mmio_rsp_data, 64'h5555_5555_5555_5555);
      tick;
      chk("afu_hi.v", 64'(mmio.mmio_rsp_valid), 64'd1);
      chk("afu_hi.tid", 64'(mmio.mmio_rsp_tid), 64'h12);
      chk("afu_hi.d", mmio.mmio_rsp_data, 64'hAAAA_AAAA_AAAA_AAAA);
      tick;
      chk("afu.v0", 64'(mmio.mmio_rsp_valid), 64'd0);

      wr(16'h0020, 64'hFFFF_FFFF_1234_5678);
      chk("wr.en", 64'(wr_en), 64'd1);
      chk("wr.data", 64'(wr_data), 64'h1234_5678);
      tick;
      chk("wr.en0", 64'(wr_en), 64'd0);
      rd("wcnt1", 16'h0014, 9'h009, 64'd1);
      rd("slot0", 16'h0020, 9'h007, 64'h0000_0000_CAFE_F00D);

      // Soft reset: trigger with a simultaneous read of RESET_CSR.
      mmio.mmio_wr_valid = 1'b1;
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = 16'h0010;
      mmio.mmio_wr_data  = 64'd1;
      mmio.mmio_rd_tid   = 9'h021;
      tick;
      idle;
      chk("srst.arn_lo", 64'(arn), 64'd0);
      mmio.mmio_wr_valid = 1'b1;
      mmio.mmio_addr     = 16'h0020;
      mmio.mmio_wr_data  = 64'h0000_DEAD;
      tick;
      idle;
      chk("srst.pre.v", 64'(mmio.mmio_rsp_valid), 64'd1);
      chk("srst.pre.tid", 64'(mmio.mmio_rsp_tid), 64'h21);
      chk("srst.pre.d", mmio.mmio_rsp_data, 64'd0);
      chk("srst.drop", 64'(wr_en), 64'd0);
      tick;
      tick;
      tick;
      wr(16'h0010, 64'd1);
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = 16'h0010;
      mmio.mmio_rd_tid   = 9'h022;
      tick;
      idle;
      tick;
      chk("srst.act", mmio.mmio_rsp_data, 64'd1);
      for (int i = 8; i < 21; i++) tick;
      chk("srst.t21", 64'(arn), 64'd0);
      tick;
      chk("srst.t22", 64'(arn), 64'd1);
      rd("wcnt0", 16'h0014, 9'h00A, 64'd0);
      rd("srst.idle", 16'h0010, 9'h00B, 64'd0);
      wr(16'h0020, 64'h1);
      chk("wr2.en", 64'(wr_en), 64'd1);
      tick;
      rd("wcnt_after", 16'h0014, 9'h00C, 64'd1);

      wr(16'h0021, 64'h1);
      chk("odd.wen", 64'(wr_en), 64'd0);
      tick;
      rd("odd.rd", 16'h0021, 9'h003, 64'd0);
      rd("odd.dfh", 16'h0001, 9'h004, 64'd0);
      rd("odd.wcnt", 16'h0014, 9'h00D, 64'd1);

      // Two cycle-counter reads issued 10 cycles apart.
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = 16'h0012;
      tick;
      idle;
      tick;
      c0 = mmio.mmio_rsp_data;
      chk("cyc0.v", 64'(mmio.mmio_rsp_valid), 64'd1);
      for (int i = 2; i < 10; i++) tick;
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = 16'h0012;
      tick;
      idle;
      tick;
      c1 = mmio.mmio_rsp_data;
      chk("cyc1.v", 64'(mmio.mmio_rsp_valid), 64'd1);
`ifdef CSR_MGR_CYCLE_COUNTER_EN
      chk("cyc.diff", c1 - c0, 64'd10);
`else
      chk("cyc.c0", c0, 64'd0);
      chk("cyc.c1", c1, 64'd0);
`endif
      tick;

      // reset_n while a read is in flight drops the response.
      mmio.mmio_rd_valid = 1'b1;
      mmio.mmio_addr     = 16'h0000;
      mmio.mmio_rd_tid   = 9'h009;
      tick;
      idle;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid.v", 64'(mmio.mmio_rsp_valid), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick;
      chk("mid.v1", 64'(mmio.mmio_rsp_valid), 64'd0);
      tick;
      chk("mid.v2", 64'(mmio.mmio_rsp_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
